// File: rtl/alu_seq.sv
// Handshaked sequential ALU. Single-cycle arithmetic, logic, shift and compare ops
// finish at the acceptance edge. MUL, DIV and REM iterate once per bit on operand
// magnitudes and then apply the sign. Results stay registered until they are consumed.
module alu_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Mode,
  input  logic [3:0]         OpCode,
  input  logic [SHAMT_W-1:0] Shift_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Result,
  output logic               Overflow,
  output logic               zero_flag,
  output logic               div_zero,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0101;
  localparam logic [3:0] OpSra = 4'b0110;
  localparam logic [3:0] OpGt  = 4'b0111;
  localparam logic [3:0] OpLt  = 4'b1000;
  localparam logic [3:0] OpMul = 4'b1001;
  localparam logic [3:0] OpDiv = 4'b1010;
  localparam logic [3:0] OpRem = 4'b1011;

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic              mode_q, mode_d;
  // hi/lo: product accumulator for MUL, remainder/quotient for DIV and REM
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic              neg_q, neg_d;         // negate product / quotient
  logic              neg_rem_q, neg_rem_d; // negate remainder (dividend negative)
  logic              div_ovf_q, div_ovf_d; // signed MIN / -1
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              divz_q, divz_d;

  // Single-cycle datapath signals
  logic [WIDTH:0]    add_w, sub_w;
  logic [WIDTH-1:0]  sc_res;
  logic              sc_ovf;
  logic              sa, sb;
  logic [WIDTH-1:0]  abs_a, abs_b;

  // Iterative-step and sign-fix signals
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_rs, div_rd;
  logic              div_ge;
  logic [2*WIDTH-1:0] mul_mag, mul_s;
  logic [WIDTH-1:0]  quo_s, rem_s;
  logic              mul_ovf;

  assign in_ready  = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign zero_flag = zero_q;
  assign div_zero  = divz_q;

  // Single-cycle result and overflow straight from the input operands
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sa     = A[WIDTH-1];
    sb     = B[WIDTH-1];
    add_w  = {1'b0, A} + {1'b0, B};
    sub_w  = {1'b0, A} - {1'b0, B};
    abs_a  = (Mode && sa) ? -A : A;
    abs_b  = (Mode && sb) ? -B : B;
    case (OpCode)
      OpAdd: begin
        sc_res = add_w[WIDTH-1:0];
        sc_ovf = Mode ? ((sa == sb) && (add_w[WIDTH-1] != sa)) : add_w[WIDTH];
      end
      OpSub: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_ovf = Mode ? ((sa != sb) && (sub_w[WIDTH-1] != sa)) : sub_w[WIDTH];
      end
      OpAnd: sc_res = A & B;
      OpOr:  sc_res = A | B;
      OpSll: sc_res = A << Shift_amt;
      OpSrl: sc_res = A >> Shift_amt;
      OpSra: sc_res = $unsigned($signed(A) >>> Shift_amt);
      OpGt:  sc_res = {{(WIDTH-1){1'b0}}, Mode ? ($signed(A) > $signed(B)) : (A > B)};
      OpLt:  sc_res = {{(WIDTH-1){1'b0}}, Mode ? ($signed(A) < $signed(B)) : (A < B)};
      default: begin
        sc_res = '0;
        sc_ovf = 1'b0;
      end
    endcase
  end

  // One shift-add / restoring-subtract step, plus the sign fix applied in FIX
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rs  = {hi_q, lo_q[WIDTH-1]};
    div_rd  = div_rs - {1'b0, opnd_q};
    // Shifted remainder is below twice the divisor, so bit WIDTH of the difference is the borrow
    div_ge  = ~div_rd[WIDTH];
    mul_mag = {hi_q, lo_q};
    mul_s   = neg_q ? -mul_mag : mul_mag;
    quo_s   = neg_q ? -lo_q : lo_q;
    rem_s   = neg_rem_q ? -hi_q : hi_q;
    mul_ovf = mode_q ? (mul_s[2*WIDTH-1:WIDTH] != {WIDTH{mul_s[WIDTH-1]}})
                     : (hi_q != '0);
  end

  // Next-state and next-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mode_d    = mode_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div_ovf_d = div_ovf_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    divz_d    = divz_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d   = OpCode;
          mode_d = Mode;
          if (OpCode == OpMul) begin
            hi_d      = '0;
            lo_d      = abs_b;
            opnd_d    = abs_a;
            neg_d     = Mode && (sa != sb);
            neg_rem_d = 1'b0;
            div_ovf_d = 1'b0;
            cnt_d     = CntW'(WIDTH);
            state_d   = StIter;
          end else if ((OpCode == OpDiv) || (OpCode == OpRem)) begin
            if (B == '0) begin
              result_d = (OpCode == OpDiv) ? '1 : A;
              ovf_d    = 1'b0;
              divz_d   = 1'b1;
              zero_d   = (((OpCode == OpDiv) ? '1 : A) == '0);
              state_d  = StDone;
            end else begin
              hi_d      = '0;
              lo_d      = abs_a;
              opnd_d    = abs_b;
              neg_d     = Mode && (sa != sb);
              neg_rem_d = Mode && sa;
              div_ovf_d = Mode && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
              cnt_d     = CntW'(WIDTH);
              state_d   = StIter;
            end
          end else begin
            result_d = sc_res;
            ovf_d    = sc_ovf;
            divz_d   = 1'b0;
            zero_d   = (sc_res == '0);
            state_d  = StDone;
          end
        end
      end
      StIter: begin
        if (op_q == OpMul) begin
          {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
        end else begin
          hi_d = div_ge ? div_rd[WIDTH-1:0] : div_rs[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ge};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        divz_d = 1'b0;
        if (op_q == OpMul) begin
          result_d = mul_s[WIDTH-1:0];
          ovf_d    = mul_ovf;
          zero_d   = (mul_s[WIDTH-1:0] == '0);
        end else if (op_q == OpDiv) begin
          result_d = quo_s;
          ovf_d    = div_ovf_q;
          zero_d   = (quo_s == '0);
        end else begin
          result_d = rem_s;
          ovf_d    = 1'b0;
          zero_d   = (rem_s == '0);
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; synchronous reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      mode_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div_ovf_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mode_q    <= mode_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div_ovf_q <= div_ovf_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      divz_q    <= divz_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expected values.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        Mode;
  logic [3:0]  OpCode;
  logic [4:0]  Shift_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Overflow, zero_flag, div_zero, busy;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic all_busy, any_rdy;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Mode      (Mode),
    .OpCode    (OpCode),
    .Shift_amt (Shift_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Overflow  (Overflow),
    .zero_flag (zero_flag),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at edge 0, then count edges until out_valid (bounded)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic m,
                       input logic [3:0] op, input logic [4:0] sh);
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    A = a; B = b; Mode = m; OpCode = op; Shift_amt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 32'hDEAD_BEEF; B = 32'h1234_5678; OpCode = 4'b0000; // must be ignored
    lat = 0;
    all_busy = 1'b1;
    any_rdy = 1'b0;
    while (!out_valid && lat < 100) begin
      all_busy &= busy;
      any_rdy  |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    all_busy &= busy;
    any_rdy  |= in_ready;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic ovf,
                         input logic zf, input logic dz, input int exp_lat);
    chk({tag, "_result"}, Result, res);
    chk({tag, "_ovf"}, {31'b0, Overflow}, {31'b0, ovf});
    chk({tag, "_zero"}, {31'b0, zero_flag}, {31'b0, zf});
    chk({tag, "_divz"}, {31'b0, div_zero}, {31'b0, dz});
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Mode = 1'b0; OpCode = '0; Shift_amt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", Result, 32'd0);
    chk("rst_flags", {29'b0, Overflow, zero_flag, div_zero}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Signed MUL -3 * 7 = -21
    issue(32'hFFFF_FFFD, 32'd7, 1'b1, 4'b1001, 5'd0);
    chk_out("smul", 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, 33);
    chk("smul_busy", {31'b0, all_busy}, 32'd1);
    chk("smul_no_ready", {31'b0, any_rdy}, 32'd0);
    consume();
    chk("smul_idle_busy", {31'b0, busy}, 32'd0);

    // Unsigned MUL 2^16 * 2^16 wraps to 0
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 4'b1001, 5'd0);
    chk_out("umul_ovf", 32'd0, 1'b1, 1'b1, 1'b0, 33);
    consume();

    // Signed MUL 2^16 * 2^16 overflows too
    issue(32'h0001_0000, 32'h0001_0000, 1'b1, 4'b1001, 5'd0);
    chk_out("smul_ovf", 32'd0, 1'b1, 1'b1, 1'b0, 33);
    consume();

    // Signed DIV / REM -7, 2
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 4'b1010, 5'd0);
    chk_out("sdiv", 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 33);
    consume();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 4'b1011, 5'd0);
    chk_out("srem", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33);
    consume();

    // Unsigned DIV 100 / 7 = 14, REM 2
    issue(32'd100, 32'd7, 1'b0, 4'b1010, 5'd0);
    chk_out("udiv", 32'd14, 1'b0, 1'b0, 1'b0, 33);
    consume();
    issue(32'd100, 32'd7, 1'b0, 4'b1011, 5'd0);
    chk_out("urem", 32'd2, 1'b0, 1'b0, 1'b0, 33);
    consume();

    // Signed MIN / -1 and matching REM
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'b1010, 5'd0);
    chk_out("min_div", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 33);
    consume();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'b1011, 5'd0);
    chk_out("min_rem", 32'd0, 1'b0, 1'b1, 1'b0, 33);
    consume();

    // Divide by zero
    issue(32'd5, 32'd0, 1'b0, 4'b1010, 5'd0);
    chk_out("div0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 0);
    consume();
    issue(32'd5, 32'd0, 1'b1, 4'b1011, 5'd0);
    chk_out("rem0", 32'd5, 1'b0, 1'b0, 1'b1, 0);
    consume();

    // Unsigned ADD carry-out, then 3 cycles of back-pressure
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 4'b0000, 5'd0);
    chk_out("uadd", 32'd0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", Result, 32'd0);
      chk("hold_flags", {29'b0, Overflow, zero_flag, div_zero}, 32'b110);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    consume();
    chk("post_consume_valid", {31'b0, out_valid}, 32'd0);

    // Signed ADD overflow, unsigned SUB borrow
    issue(32'h7FFF_FFFF, 32'd1, 1'b1, 4'b0000, 5'd0);
    chk_out("sadd_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 0);
    consume();
    issue(32'd3, 32'd5, 1'b0, 4'b0001, 5'd0);
    chk_out("usub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 0);
    consume();

    // Logic and shifts
    issue(32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 4'b0010, 5'd0);
    chk_out("and", 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 0);
    consume();
    issue(32'h8000_0000, 32'd0, 1'b1, 4'b0110, 5'd4);
    chk_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 0);
    consume();
    issue(32'h8000_0000, 32'd0, 1'b0, 4'b0101, 5'd4);
    chk_out("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0, 0);
    consume();

    // Compares
    issue(32'hFFFF_FFFF, 32'd1, 1'b1, 4'b1000, 5'd0);
    chk_out("slt", 32'd1, 1'b0, 1'b0, 1'b0, 0);
    consume();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 4'b1000, 5'd0);
    chk_out("ult", 32'd0, 1'b0, 1'b1, 1'b0, 0);
    consume();

    // Undefined opcode
    issue(32'd9, 32'd9, 1'b0, 4'b1111, 5'd0);
    chk_out("undef", 32'd0, 1'b0, 1'b1, 1'b0, 0);
    consume();

    // Reset on iteration 10 of a MUL
    chk("mulrst_in_ready", {31'b0, in_ready}, 32'd1);
    A = 32'd12345; B = 32'd678; Mode = 1'b0; OpCode = 4'b1001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("mulrst_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mulrst_in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("mulrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mulrst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mulrst_in_ready_rel", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mulrst_still_no_valid", {31'b0, out_valid}, 32'd0);
    issue(32'd2, 32'd3, 1'b0, 4'b0000, 5'd0);
    chk_out("add_after_rst", 32'd5, 1'b0, 1'b0, 1'b0, 0);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
